// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for one single-port synchronous memory: range/alignment check, 1-cycle response.
// Optional ARB_ROUND_ROBIN_EN replaces fixed priority plus starvation guard with round-robin.

module mpa_resp_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  grant,
  input  logic                  legal,
  input  logic                  is_write,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata
);
  logic rd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      resp_valid <= grant;
      resp_err   <= grant & ~legal;
      rd_q       <= grant & legal & ~is_write;
    end
  end

  // mem_dout is the registered read of the address driven in the grant cycle
  assign resp_rdata = rd_q ? mem_dout : '0;
endmodule

module mem_port_arbiter #(
  parameter int MEM_SIZE     = 4096,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic                  m0_req_we,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata,
  output logic                  m0_resp_valid,
  output logic [DATA_WIDTH-1:0] m0_resp_rdata,
  output logic                  m0_resp_err,
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic                  m1_req_we,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata,
  output logic                  m1_resp_valid,
  output logic [DATA_WIDTH-1:0] m1_resp_rdata,
  output logic                  m1_resp_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);
  localparam int NM = 2;
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(MEM_SIZE - 4);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  req_t [NM-1:0]                  req;
  req_t                           sel;
  logic [NM-1:0]                  req_valid, grant, resp_valid, resp_err;
  logic [NM-1:0][DATA_WIDTH-1:0]  resp_rdata;
  logic                           m0_wins, legal, rd_go, wr_go;
  logic [ADDR_WIDTH-1:0]          raddr_q, waddr_q;
  logic [DATA_WIDTH-1:0]          din_q;

  assign req[0]    = {m0_req_we, m0_req_addr, m0_req_wdata};
  assign req[1]    = {m1_req_we, m1_req_addr, m1_req_wdata};
  assign req_valid = {m1_req_valid, m0_req_valid};

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_q;  // master holding priority on the next contended cycle

  assign m0_wins = ~req_valid[1] | ~rr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    rr_q <= 1'b0;
    else if (|grant) rr_q <= grant[0];
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  assign m0_wins = ~req_valid[1] | (starve_cnt != LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          starve_cnt <= '0;
    else if (!req_valid[1] || grant[1])    starve_cnt <= '0;
    else if (grant[0] && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
  end
`endif

  // Gate with reset_n so nothing is accepted or written while reset is held
  assign grant[0] = reset_n & req_valid[0] & m0_wins;
  assign grant[1] = reset_n & req_valid[1] & ~grant[0];

  assign m0_req_ready = grant[0];
  assign m1_req_ready = grant[1];

  assign sel   = grant[1] ? req[1] : req[0];
  assign legal = (sel.addr[1:0] == 2'b00) && (sel.addr <= MAX_ADDR);
  assign rd_go = (|grant) & legal & ~sel.we;
  assign wr_go = (|grant) & legal & sel.we;

  // Memory buses hold their last value when unused to avoid needless toggling
  assign mem_we    = wr_go;
  assign mem_raddr = rd_go ? sel.addr  : raddr_q;
  assign mem_waddr = wr_go ? sel.addr  : waddr_q;
  assign mem_din   = wr_go ? sel.wdata : din_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raddr_q <= '0;
      waddr_q <= '0;
      din_q   <= '0;
    end else begin
      raddr_q <= mem_raddr;
      waddr_q <= mem_waddr;
      din_q   <= mem_din;
    end
  end

  for (genvar i = 0; i < NM; i++) begin : g_lane
    mpa_resp_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .grant     (grant[i]),
      .legal     (legal),
      .is_write  (sel.we),
      .mem_dout  (mem_dout),
      .resp_valid(resp_valid[i]),
      .resp_err  (resp_err[i]),
      .resp_rdata(resp_rdata[i])
    );
  end

  assign m0_resp_valid = resp_valid[0];
  assign m0_resp_err   = resp_err[0];
  assign m0_resp_rdata = resp_rdata[0];
  assign m1_resp_valid = resp_valid[1];
  assign m1_resp_err   = resp_err[1];
  assign m1_resp_rdata = resp_rdata[1];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected responses, monitor pops.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_req_valid = 0, m0_req_we = 0, m1_req_valid = 0, m1_req_we = 0;
  logic [31:0] m0_req_addr = 0, m0_req_wdata = 0, m1_req_addr = 0, m1_req_wdata = 0;
  logic        m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, m0_resp_err, m1_resp_err;
  logic [31:0] m0_resp_rdata, m1_resp_rdata;
  logic        mem_we;
  logic [31:0] mem_raddr, mem_waddr, mem_din;
  logic [31:0] mem_dout = 0;

  mem_port_arbiter #(.MEM_SIZE(4096), .ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_resp_valid(m0_resp_valid),
    .m0_resp_rdata(m0_resp_rdata), .m0_resp_err(m0_resp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_resp_valid(m1_resp_valid),
    .m1_resp_rdata(m1_resp_rdata), .m1_resp_err(m1_resp_err),
    .mem_we(mem_we), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with registered read
  logic [31:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr[11:2]] <= mem_din;
    mem_dout <= mem[mem_raddr[11:2]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic err; logic [31:0] rdata; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (m0_resp_valid) begin
      if (q0.size() == 0) flag("m0_unexpected_resp");
      else begin
        e = q0.pop_front();
        cmp("m0_resp_cycle", cyc, e.due);
        cmp("m0_resp_err", {31'b0, m0_resp_err}, {31'b0, e.err});
        cmp("m0_resp_rdata", m0_resp_rdata, e.rdata);
      end
    end else if (q0.size() != 0 && q0[0].due <= cyc) begin
      flag("m0_missing_resp");
      void'(q0.pop_front());
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (m1_resp_valid) begin
      if (q1.size() == 0) flag("m1_unexpected_resp");
      else begin
        e = q1.pop_front();
        cmp("m1_resp_cycle", cyc, e.due);
        cmp("m1_resp_err", {31'b0, m1_resp_err}, {31'b0, e.err});
        cmp("m1_resp_rdata", m1_resp_rdata, e.rdata);
      end
    end else if (q1.size() != 0 && q1[0].due <= cyc) begin
      flag("m1_missing_resp");
      void'(q1.pop_front());
    end
  end

  // One request cycle; expected grant/mem_we/response are supplied by the caller
  task automatic issue(input logic v0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic v1, input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic g0, input logic g1, input logic xwe,
                       input logic xerr, input logic [31:0] xrd);
    exp_t e;
    @(negedge clk);
    m0_req_valid = v0; m0_req_we = we0; m0_req_addr = a0; m0_req_wdata = d0;
    m1_req_valid = v1; m1_req_we = we1; m1_req_addr = a1; m1_req_wdata = d1;
    #1;
    cmp("m0_req_ready", {31'b0, m0_req_ready}, {31'b0, g0});
    cmp("m1_req_ready", {31'b0, m1_req_ready}, {31'b0, g1});
    cmp("mem_we", {31'b0, mem_we}, {31'b0, xwe});
    e.due = cyc + 1; e.err = xerr; e.rdata = xrd;
    if (g0) q0.push_back(e);
    if (g1) q1.push_back(e);
  endtask

  task automatic idle(input int n, input logic [31:0] raddr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      m0_req_valid = 0; m1_req_valid = 0;
      #1;
      cmp("idle_ready", {30'b0, m1_req_ready, m0_req_ready}, 32'h0);
      cmp("idle_mem_we", {31'b0, mem_we}, 32'h0);
      cmp("idle_mem_raddr", mem_raddr, raddr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic g1;
    // Reset: request present but nothing may be accepted or written
    m0_req_valid = 1; m0_req_we = 1; m0_req_addr = 32'h10; m0_req_wdata = 32'h1;
    repeat (3) @(negedge clk);
    cmp("rst_m0_ready", {31'b0, m0_req_ready}, 32'h0);
    cmp("rst_mem_we", {31'b0, mem_we}, 32'h0);
    cmp("rst_resp", {30'b0, m1_resp_valid, m0_resp_valid}, 32'h0);
    cmp("rst_err", {30'b0, m1_resp_err, m0_resp_err}, 32'h0);
    cmp("rst_rdata", m0_resp_rdata | m1_resp_rdata, 32'h0);
    m0_req_valid = 0;
    reset_n = 1;
    idle(2, 32'h0);

    // Write then read-after-write
    issue(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0);
    issue(1, 0, 32'h10, 32'h0,        0, 0, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF);

    // Illegal accesses (misaligned, one past end) and the last legal word
    issue(0, 0, 0, 0, 1, 0, 32'h1002, 32'h0,        0, 1, 0, 1, 32'h0);
    issue(0, 0, 0, 0, 1, 1, 32'h1000, 32'h12345678, 0, 1, 0, 1, 32'h0);
    issue(0, 0, 0, 0, 1, 1, 32'h0FFC, 32'hA5A50FFC, 0, 1, 1, 0, 32'h0);
    issue(0, 0, 0, 0, 1, 0, 32'h0FFC, 32'h0,        0, 1, 0, 0, 32'hA5A50FFC);
    issue(1, 0, 32'h3,  32'h0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0);
    idle(1, 32'h0FFC);

    // Back-to-back mixed masters
    issue(1, 0, 32'h0, 0, 0, 0, 0, 0,          1, 0, 0, 0, 32'h0);
    issue(0, 0, 0, 0, 1, 1, 32'h4, 32'h5,      0, 1, 1, 0, 32'h0);
    issue(1, 0, 32'h4, 0, 0, 0, 0, 0,          1, 0, 0, 0, 32'h5);

    // Continuous contention
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      g1 = (i % 2 == 0);
`else
      g1 = (i % 5 == 4);
`endif
      issue(1, 0, 32'h10, 0, 1, 0, 32'h0FFC, 0, !g1, g1, 0, 0,
            g1 ? 32'hA5A50FFC : 32'hDEADBEEF);
    end
    idle(1, g1 ? 32'h0FFC : 32'h10);

    // Reset asserted in the response cycle of an accepted read
    @(negedge clk);
    m0_req_valid = 1; m0_req_we = 0; m0_req_addr = 32'h10;
    #1;
    cmp("mid_accept", {31'b0, m0_req_ready}, 32'h1);
    @(posedge clk);
    #1;
    reset_n = 0;
    m0_req_valid = 0;
    @(negedge clk);
    cmp("mid_rst_resp", {30'b0, m1_resp_valid, m0_resp_valid}, 32'h0);
    cmp("mid_rst_rdata", m0_resp_rdata | m1_resp_rdata, 32'h0);
    cmp("mid_rst_mem_we", {31'b0, mem_we}, 32'h0);
    @(negedge clk);
    reset_n = 1;
    idle(2, 32'h0);
    issue(1, 0, 32'h4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h5);

    // Idle: memory buses hold the last read address
    idle(10, 32'h4);

    repeat (2) @(negedge clk);
    cmp("q0_drained", q0.size(), 32'h0);
    cmp("q1_drained", q1.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, word-wide synchronous memory macro between two requesters.
  - Master 0: instruction fetch.
  - Master 1: load/store.
- Has a valid/ready request handshake per master and a fixed-latency response.
- Issues at most one memory operation per cycle and tracks the 1-cycle registered read latency of the memory.
- Guards master 1 against starvation and rejects out-of-range or misaligned accesses before they reach the memory.

Parameters:
- MEM_SIZE, 4096: memory size in bytes; legal word addresses are 0 .. MEM_SIZE-4.
- ADDR_WIDTH, 32: byte address width.
- DATA_WIDTH, 32: data word width.
- STARVE_LIMIT, 4: consecutive contended grants to master 0 before master 1 is forced; range 1..15.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mN_req_valid  in  1  request present (N = 0, 1; same set for each master).
- mN_req_ready  out  1  request accepted this cycle.
- mN_req_we  in  1  1 = write, 0 = read.
- mN_req_addr  in  ADDR_WIDTH  byte address.
- mN_req_wdata  in  DATA_WIDTH  write data.
- mN_resp_valid  out  1  response for the request accepted in the previous cycle.
- mN_resp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- mN_resp_err  out  1  request was rejected (range or alignment); qualified by resp_valid.
- mem_we  out  1  memory write enable.
- mem_raddr  out  ADDR_WIDTH  memory read byte address.
- mem_waddr  out  ADDR_WIDTH  memory write byte address.
- mem_din  out  DATA_WIDTH  memory write data.
- mem_dout  in  DATA_WIDTH  memory read data, registered one cycle after mem_raddr.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While reset_n = 0: req_ready, resp_valid, resp_err and mem_we are 0; resp_rdata is 0.
  - starve_cnt = 0; rr pointer = master 0.
- Grant (combinational, same cycle):
  - Only one master valid: that master is granted.
  - Both valid: master 0 wins unless starve_cnt == STARVE_LIMIT, in which case master 1 wins.
  - mN_req_ready = grant_N. A transfer completes when valid & ready. Ready never asserts without valid.
- Legality check on the granted request: addr[1:0] == 0 and addr <= MEM_SIZE-4.
  - Illegal request: still accepted (ready = 1), mem_we held 0, response carries err = 1.
- Memory drive in the grant cycle:
  - Legal read: mem_raddr = addr, mem_we = 0.
  - Legal write: mem_waddr = addr, mem_din = wdata, mem_we = 1.
  - No grant: mem_we = 0, addresses hold their last registered value (avoids useless toggling).
- Response (registered): exactly one cycle after acceptance.
  - mN_resp_valid = 1 for one cycle; resp_err as registered.
  - resp_rdata = mem_dout for a legal read, else 0.
  - No response backpressure: masters must sink responses.
- Throughput: back-to-back accepts every cycle. A response and a new accept may occur in the same cycle, for either master.
- starve_cnt (4-bit):
  - Increments when master 0 is granted while m1_req_valid = 1.
  - Clears when master 1 is granted or m1_req_valid = 0.
  - Saturates at STARVE_LIMIT.
- Read-after-write to the same address in consecutive cycles returns the new data; the memory write commits before the later read samples.
- Reset asserted mid-operation: any pending response is dropped; no resp_valid after reset release without a new request.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - Contention is resolved by a 1-bit rr pointer. The master not granted last wins; the pointer updates on every grant.
  - starve_cnt and STARVE_LIMIT are unused and removed.
- ARB_ROUND_ROBIN_EN undefined: fixed priority with starvation guard, as above.

Test Plan:
- Single write then read: m0 writes 0xDEADBEEF to 0x10 in cycle T, reads 0x10 in T+1 → m0_resp_valid in T+1 (err 0, rdata 0) and T+2 with rdata 0xDEADBEEF.
- Continuous contention, STARVE_LIMIT = 4: both valid every cycle → m0 granted 4 cycles, m1 the 5th, pattern repeats. With ARB_ROUND_ROBIN_EN, grants alternate m0, m1, m0, ...
- Illegal addresses: m1 reads 0x1002 → accepted; next cycle m1_resp_err = 1, rdata 0. m1 writes 0x1000 with MEM_SIZE = 4096 → mem_we stays 0, err = 1, memory unchanged.
- Back-to-back mixed: m0 reads 0x0, m1 writes 0x4 = 0x5, m0 reads 0x4 in consecutive cycles → responses on consecutive cycles, last rdata = 0x5.
- Reset mid-flight: assert reset_n low in the cycle after acceptance of a read → no resp_valid; all outputs 0; first post-reset request behaves normally.
- Idle: no requests for 10 cycles → mem_we = 0 throughout, no resp_valid, mem_raddr unchanged.
